rx_oversampled_frontend: RTL and testbench

Parametrised UART receive front end that succeeds the fixed 8–11-bit frame receiver. It synchronises the serial input and validates the start bit. It deserialises 5..MAX_DATA_BITS data bits with optional parity and 1 or 2 stop bits, then reports the aligned data word with parity, framing and break status as one-cycle results. It sits between the `uart_rx` pad and the RX FIFO / Wishbone register block.

---
 rtl/rx_oversampled_frontend_if.sv | 20 ++
 rtl/rx_oversampled_frontend.sv | 162 ++++++++++++++++
 tb/tb_rx_oversampled_frontend.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rx_oversampled_frontend_if.sv
// Result bus from the UART receive front end to the RX FIFO / register block.
// The front end drives it through the master modport; consumers use slave.
interface rx_oversampled_frontend_if #(
   parameter int MAX_DATA_BITS = 9
);
   logic [MAX_DATA_BITS-1:0] data_o;
   logic                     parity_err_o;
   logic                     frame_err_o;
   logic                     break_o;
   logic                     valid_o;
   logic                     busy_o;

   modport master (
      output data_o, parity_err_o, frame_err_o, break_o, valid_o, busy_o
   );

   modport slave (
      input  data_o, parity_err_o, frame_err_o, break_o, valid_o, busy_o
   );
endinterface

// File: rtl/rx_oversampled_frontend.sv
// UART receive front end: synchroniser, start validation, 5..MAX_DATA_BITS deserialiser,
// parity / framing / break detection. Optional 3-sample vote: define RX_MAJORITY_VOTE_EN.
module rx_oversampled_frontend #(
   parameter int SYNC_STAGES   = 3,
   parameter int MAX_DATA_BITS = 9,
   parameter int CLK_DIV_WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [CLK_DIV_WIDTH-1:0] cr_clk_div_i,
   input  logic [3:0]               cr_dbits_i,
   input  logic [1:0]               cr_p_i,
   input  logic                     cr_s_i,
   input  logic                     uart_rx_i,
   rx_oversampled_frontend_if.master res
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PARITY    = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     rx_s;
   logic                     smp;
   logic [2:0]               state_q;
   logic [CLK_DIV_WIDTH-1:0] div_in, div_q, baud_q;
   logic [3:0]               dbits_in, dbits_q, bit_q;
   logic [1:0]               par_q;
   logic                     stop2_q;
   logic [MAX_DATA_BITS-1:0] shreg_q, data_q;
   logic                     acc_q, any_one_q, stop_err_q;
   logic                     parity_err_q, frame_err_q, break_q, valid_q;
   logic                     tick;

   // NOTE: every sequential block uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '1;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef RX_MAJORITY_VOTE_EN
   // The stage ahead of rx_s already holds next cycle's rx_s, so the vote adds no latency.
   logic rx_prev_q;
   logic rx_next;
   assign rx_next = sync_q[SYNC_STAGES-2];
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rx_prev_q <= 1'b1;
      else         rx_prev_q <= rx_s;
   end
   assign smp = (rx_prev_q & rx_s) | (rx_s & rx_next) | (rx_prev_q & rx_next);
`else
   assign smp = rx_s;
`endif

   assign div_in   = (cr_clk_div_i < CLK_DIV_WIDTH'(4)) ? CLK_DIV_WIDTH'(4) : cr_clk_div_i;
   assign dbits_in = (cr_dbits_i < 4'd5)                ? 4'd5 :
                     (cr_dbits_i > 4'(MAX_DATA_BITS))   ? 4'(MAX_DATA_BITS) : cr_dbits_i;
   assign tick     = (baud_q == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         div_q        <= '0;
         dbits_q      <= '0;
         par_q        <= '0;
         stop2_q      <= 1'b0;
         baud_q       <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         acc_q        <= 1'b0;
         any_one_q    <= 1'b0;
         stop_err_q   <= 1'b0;
         data_q       <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         break_q      <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (!rx_s) begin
               state_q <= ST_START;
               div_q   <= div_in;
               dbits_q <= dbits_in;
               par_q   <= cr_p_i;
               stop2_q <= cr_s_i;
               baud_q  <= (div_in >> 1) - 1'b1;
            end
            ST_START: begin
               if (!tick) baud_q <= baud_q - 1'b1;
               else if (smp) state_q <= ST_IDLE;
               else begin
                  state_q    <= ST_DATA;
                  baud_q     <= div_q - 1'b1;
                  bit_q      <= '0;
                  shreg_q    <= '0;
                  acc_q      <= (par_q == 2'b01);
                  any_one_q  <= 1'b0;
                  stop_err_q <= 1'b0;
               end
            end
            ST_DATA: begin
               if (!tick) baud_q <= baud_q - 1'b1;
               else begin
                  baud_q         <= div_q - 1'b1;
                  shreg_q[bit_q] <= smp;
                  acc_q          <= acc_q ^ smp;
                  any_one_q      <= any_one_q | smp;
                  if (bit_q == dbits_q - 4'd1) begin
                     bit_q   <= '0;
                     state_q <= (par_q != 2'b00) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_q <= bit_q + 4'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (!tick) baud_q <= baud_q - 1'b1;
               else begin
                  baud_q    <= div_q - 1'b1;
                  acc_q     <= acc_q ^ smp;
                  any_one_q <= any_one_q | smp;
                  state_q   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (!tick) baud_q <= baud_q - 1'b1;
               else begin
                  baud_q <= div_q - 1'b1;
                  if (bit_q == {3'b000, stop2_q}) begin
                     valid_q      <= 1'b1;
                     data_q       <= shreg_q;
                     parity_err_q <= (par_q != 2'b00) & acc_q;
                     frame_err_q  <= stop_err_q | ~smp;
                     break_q      <= ~(any_one_q | smp);
                     // A low final stop means the line may be held in break; wait for it to rise.
                     state_q      <= smp ? ST_IDLE : ST_WAIT_HIGH;
                  end else begin
                     stop_err_q <= stop_err_q | ~smp;
                     any_one_q  <= any_one_q | smp;
                     bit_q      <= bit_q + 4'd1;
                  end
               end
            end
            ST_WAIT_HIGH: if (rx_s) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign res.data_o       = data_q;
   assign res.parity_err_o = parity_err_q;
   assign res.frame_err_o  = frame_err_q;
   assign res.break_o      = break_q;
   assign res.valid_o      = valid_q;
   assign res.busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_oversampled_frontend.sv
// Directed bench for rx_oversampled_frontend: frame formats, clamps, false start,
// break handling, mid-frame reset and the single-cycle glitch case.
module tb_rx_oversampled_frontend;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cr_div = 16'd16;
   logic [3:0]  cr_dbits = 4'd8;
   logic [1:0]  cr_p = 2'b00;
   logic        cr_s = 1'b0;
   logic        uart_rx = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_valid = 0;
   int v_cyc = 0;

   rx_oversampled_frontend_if #(.MAX_DATA_BITS(9)) res ();

   rx_oversampled_frontend #(
      .SYNC_STAGES(3), .MAX_DATA_BITS(9), .CLK_DIV_WIDTH(16)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .cr_clk_div_i(cr_div), .cr_dbits_i(cr_dbits),
      .cr_p_i(cr_p), .cr_s_i(cr_s), .uart_rx_i(uart_rx), .res(res.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (res.valid_o) begin
      n_valid = n_valid + 1;
      v_cyc   = cyc;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one frame; bit 0 of fr is the start bit. Returns the first drive cycle.
   task automatic send(input logic [15:0] fr, input int nb, input int d, input int glitch,
                       output int c);
      for (int k = 0; k < nb * d; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) c = cyc;
         uart_rx = fr[k / d] ^ (k == glitch);
      end
      @(posedge clk);
      #1 uart_rx = 1'b1;
      repeat (2 * d) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int p0, input int c, input int off,
                              input logic [8:0] d, input logic pe, input logic fe,
                              input logic brk);
      check({tag, " pulses"}, n_valid - p0, 1);
      check({tag, " cycle"}, v_cyc - c, off);
      check({tag, " data"}, res.data_o, d);
      check({tag, " parity"}, res.parity_err_o, pe);
      check({tag, " frame"}, res.frame_err_o, fe);
      check({tag, " break"}, res.break_o, brk);
   endtask

   initial begin
      int c;
      int p0;
      logic [8:0] glitch_exp;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst data", res.data_o, 0);
      check("rst parity", res.parity_err_o, 0);
      check("rst frame", res.frame_err_o, 0);
      check("rst break", res.break_o, 0);
      check("rst valid", res.valid_o, 0);
      check("rst busy", res.busy_o, 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // 8N1, 0xA5, D=16: valid at T0+153 where T0 = drive cycle + 3
      p0 = n_valid;
      send({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16, -1, c);
      check_frame("8n1_a5", p0, c, 156, 9'h0A5, 1'b0, 1'b0, 1'b0);

      // 7 data bits, even parity, 2 stops, wrong parity bit
      cr_dbits = 4'd7; cr_p = 2'b10; cr_s = 1'b1;
      p0 = n_valid;
      send({5'b0, 2'b11, 1'b1, 7'h41, 1'b0}, 11, 16, -1, c);
      check_frame("7e2_41", p0, c, 172, 9'h041, 1'b1, 1'b0, 1'b0);

      // 9 data bits, odd parity, correct parity bit 0
      cr_dbits = 4'd9; cr_p = 2'b01; cr_s = 1'b0;
      p0 = n_valid;
      send({4'b0, 1'b1, 1'b0, 9'h1FF, 1'b0}, 12, 16, -1, c);
      check_frame("9o1_1ff", p0, c, 188, 9'h1FF, 1'b0, 1'b0, 1'b0);

      // cr_dbits=3 clamps to 5 data bits
      cr_dbits = 4'd3; cr_p = 2'b00;
      p0 = n_valid;
      send({9'b0, 1'b1, 5'h15, 1'b0}, 7, 16, -1, c);
      check_frame("5n1_clamp", p0, c, 108, 9'h015, 1'b0, 1'b0, 1'b0);

      // cr_clk_div_i=2 clamps to D=4 (half-bit 2)
      cr_dbits = 4'd8; cr_div = 16'd2;
      p0 = n_valid;
      send({6'b0, 1'b1, 8'h3C, 1'b0}, 10, 4, -1, c);
      check_frame("d4_clamp", p0, c, 42, 9'h03C, 1'b0, 1'b0, 1'b0);
      cr_div = 16'd16;

      // 4-cycle low glitch: false start, no pulse
      p0 = n_valid;
      @(posedge clk);
      #1 c = cyc;
      uart_rx = 1'b0;
      while (cyc < c + 4) @(posedge clk);
      #1 uart_rx = 1'b1;
      wait_to(c + 3 + 5);
      check("glitch busy_mid", res.busy_o, 1);
      wait_to(c + 3 + 9);
      check("glitch busy_end", res.busy_o, 0);
      repeat (200) @(posedge clk);
      @(negedge clk);
      check("glitch pulses", n_valid - p0, 0);

      // Line held low for 20 bit times
      p0 = n_valid;
      @(posedge clk);
      #1 c = cyc;
      uart_rx = 1'b0;
      wait_to(c + 200);
      check_frame("break", p0, c, 156, 9'h000, 1'b0, 1'b1, 1'b1);
      check("break wait_high busy", res.busy_o, 1);
      while (cyc < c + 320) @(posedge clk);
      #1 uart_rx = 1'b1;
      wait_to(c + 330);
      check("break idle busy", res.busy_o, 0);
      check("break single pulse", n_valid - p0, 1);
      p0 = n_valid;
      send({6'b0, 1'b1, 8'h5A, 1'b0}, 10, 16, -1, c);
      check_frame("after_break", p0, c, 156, 9'h05A, 1'b0, 1'b0, 1'b0);

      // Break again, with reset asserted mid-frame
      p0 = n_valid;
      @(posedge clk);
      #1 c = cyc;
      uart_rx = 1'b0;
      wait_to(c + 100);
      check("rstmid busy_before", res.busy_o, 1);
      rst_n = 1'b0;
      #1;
      check("rstmid data", res.data_o, 0);
      check("rstmid frame", res.frame_err_o, 0);
      check("rstmid break", res.break_o, 0);
      check("rstmid busy", res.busy_o, 0);
      uart_rx = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(posedge clk);
      @(negedge clk);
      check("rstmid pulses", n_valid - p0, 0);
      check("rstmid valid", res.valid_o, 0);

      // Single-cycle inversion at data bit 3 nominal sample (T0+8+4*16 = T0+72)
`ifdef RX_MAJORITY_VOTE_EN
      glitch_exp = 9'h000;
`else
      glitch_exp = 9'h008;
`endif
      p0 = n_valid;
      send({6'b0, 1'b1, 8'h00, 1'b0}, 10, 16, 72, c);
      check_frame("bit3_glitch", p0, c, 156, glitch_exp, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
